// File: rtl/uart_txd_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : uart_txd_monitor
// Brief   : 8N1 UART receiver with byte FIFO, framing-error and overflow flags
// Revision: 1.0
// ============================================================================
module uart_txd_monitor #(
  parameter int CLKS_PER_BIT = 174,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        rxd,
  output logic                        out_valid,
  output logic [7:0]                  out_bits,
  input  logic                        out_ready,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  logic          sync_meta;
  logic          rxs;
  logic [1:0]    settle;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitn, bit_n;
  logic [7:0]    shift, shift_n;
  logic          push;
  logic          ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, rd_next;
  logic          empty, full, pop, do_push, drop;

  // The synchronizer is preset high, so its contents are only trusted once
  // two real samples have been shifted in after reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      rxs       <= 1'b1;
      settle    <= 2'b00;
    end else begin
      sync_meta <= rxd;
      rxs       <= sync_meta;
      settle    <= {settle[0], 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= WAIT_HIGH;
      cnt   <= '0;
      bitn  <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bit_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bitn;
    shift_n  = shift;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      WAIT_HIGH: begin
        if (settle[1] && rxs) state_n = IDLE;
      end
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rxs) begin
            state_n = DATA;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          shift_n[bitn] = rxs;
          cnt_n         = '0;
          bit_n         = bitn + 3'd1;
          if (bitn == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = WAIT_HIGH;
    endcase
  end

  assign level     = wr_ptr - rd_ptr;
  assign empty     = (level == '0);
  assign full      = (level == FULL_LVL);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign do_push   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign rd_next   = rd_ptr + PTR_ONE;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shift;
  end

  // out_bits tracks the head entry; it only moves when the FIFO stays or
  // becomes non-empty, so it keeps its last value once drained.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_bits  <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_next;
        if (level > PTR_ONE)  out_bits <= mem[rd_next[AW-1:0]];
        else if (do_push)     out_bits <= shift;
      end else if (empty && do_push) begin
        out_bits <= shift;
      end
      if (ferr_set) frame_err <= 1'b1;
      if (drop)     overflow  <= 1'b1;
    end
  end

endmodule
`default_nettype wire
